// File: rtl/fp_det_pkg.sv
// Shared definitions for the determinant engine matrix loader.
// Contents: CI status codes, loader state encoding, CI configuration word layout,
// and common float constants used by the compute core.
package fp_det_pkg;

  // CI status codes returned in result alongside done
  localparam logic [31:0] ST_READY  = 32'd0;
  localparam logic [31:0] ST_BUSY   = 32'd1;
  localparam logic [31:0] ST_IRQ    = 32'd3;
  localparam logic [31:0] ST_BADDIM = 32'd4;
  localparam logic [31:0] ST_ACCEPT = 32'd99;

  // IEEE-754 single-precision constants for the compute core
  localparam logic [31:0] FLOAT_ONE = 32'h3F80_0000;
  localparam logic [31:0] FLOAT_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_ISSUE = 2'd1,
    LD_DRAIN = 2'd2,
    LD_IRQ   = 2'd3
  } ld_state_e;

  // Layout of CI operand datab
  typedef struct packed {
    logic [7:0]  rsvd;
    logic [15:0] stride;
    logic [7:0]  dim;
  } ci_cfg_t;

endpackage

// File: rtl/fp_matrix_loader_if.sv
// Bus bundle for fp_matrix_loader: Nios CI handshake, Avalon-MM read master,
// consumer buffer read port and interrupt.
// master: loader side (drives done/result/address/read/buf_rddata/load_done/irq)
// slave : environment side (CPU, SDRAM slave, compute core)
interface fp_matrix_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned BUF_AW = 10
);
  logic              start;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic              done;
  logic [31:0]       result;
  logic [ADDR_W-1:0] address;
  logic              read;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;
  logic [BUF_AW-1:0] buf_rdaddr;
  logic [DATA_W-1:0] buf_rddata;
  logic              load_done;
  logic              irq;
  logic              irq_ack;

  modport master (
    input  start, dataa, datab, readdata, readdatavalid, waitrequest, buf_rdaddr, irq_ack,
    output done, result, address, read, buf_rddata, load_done, irq
  );

  modport slave (
    output start, dataa, datab, readdata, readdatavalid, waitrequest, buf_rdaddr, irq_ack,
    input  done, result, address, read, buf_rddata, load_done, irq
  );
endinterface

// File: rtl/matrix_buf_ram.sv
// Simple dual-port matrix buffer: one write port, one registered read port.
// Ports: clk; we_i/waddr_i/wdata_i write; raddr_i read address; rdata_o data one cycle later.
// A read of the address being written in the same cycle returns the old word.
module matrix_buf_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fp_matrix_loader.sv
// Nios CI + Avalon-MM burst loader: fetches an NxN matrix (row stride in words)
// with up to MAX_PENDING reads in flight and stores it row-major in matrix_buf_ram.
// Ports: clk, reset (async, active-high); bus (master modport) carries the CI
// start/dataa/datab/done/result, Avalon address/read/readdata/readdatavalid/
// waitrequest, buffer buf_rdaddr/buf_rddata, load_done and irq/irq_ack.
module fp_matrix_loader
  import fp_det_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned MAX_DIM     = 32,
  parameter int unsigned MAX_PENDING = 8,
  parameter int unsigned BUF_AW      = 10
) (
  input logic               clk,
  input logic               reset,
  fp_matrix_loader_if.master bus
);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned CNT_W  = BUF_AW + 1;
  localparam int unsigned BYTES  = DATA_W / 8;

  localparam logic [1:0] S_IDLE  = 2'(LD_IDLE);
  localparam logic [1:0] S_ISSUE = 2'(LD_ISSUE);
  localparam logic [1:0] S_DRAIN = 2'(LD_DRAIN);
  localparam logic [1:0] S_IRQ   = 2'(LD_IRQ);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, address_q, address_d;
  logic [5:0]        dim_q, dim_d, row_q, row_d, col_q, col_d;
  logic [15:0]       stride_q, stride_d;
  logic [CNT_W-1:0]  nn_q, nn_d, wcnt_q, wcnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [31:0]       result_q, result_d;
  logic              read_q, read_d, done_q, done_d, irq_q, irq_d, ld_q, ld_d;

  ci_cfg_t cfg;
  logic    accept, rsp, dim_ok, last_req;
  logic    unused_bits;

  assign cfg         = bus.datab;
  assign unused_bits = ^{cfg.rsvd, bus.dataa[31:ADDR_W]};
  assign dim_ok      = (cfg.dim >= 8'd2) && (cfg.dim <= 8'(MAX_DIM));
  assign accept      = (state_q == S_ISSUE) && read_q && !bus.waitrequest;
  // responses are only meaningful while a load owns the buffer
  assign rsp         = bus.readdatavalid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign last_req    = (row_q == dim_q - 6'd1) && (col_q == dim_q - 6'd1);

  // Next-state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    dim_d       = dim_q;
    stride_d    = stride_q;
    nn_d        = nn_q;
    row_d       = row_q;
    col_d       = col_q;
    wcnt_d      = wcnt_q;
    pending_d   = pending_q;
    address_d   = address_q;
    read_d      = 1'b0;
    done_d      = bus.start;
    result_d    = ST_READY;
    irq_d       = irq_q;
    ld_d        = ld_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (dim_ok) begin
            result_d  = ST_ACCEPT;
            state_d   = S_ISSUE;
            base_d    = bus.dataa[ADDR_W-1:0];
            dim_d     = 6'(cfg.dim);
            stride_d  = (cfg.stride == 16'd0) ? 16'(cfg.dim) : cfg.stride;
            nn_d      = CNT_W'(cfg.dim) * CNT_W'(cfg.dim);
            row_d     = '0;
            col_d     = '0;
            wcnt_d    = '0;
            pending_d = '0;
            ld_d      = 1'b0;
          end else if (cfg.dim > 8'(MAX_DIM)) begin
            result_d = ST_BADDIM;
          end
        end
      end
      S_ISSUE: begin
        if (bus.start) result_d = ST_BUSY;
        if (accept) begin
          if (last_req) state_d = S_DRAIN;
          if (col_q == dim_q - 6'd1) begin
            col_d = '0;
            row_d = row_q + 6'd1;
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (bus.start) result_d = ST_BUSY;
        if (wcnt_q == nn_q) begin
          irq_d   = 1'b1;
          ld_d    = 1'b1;
          state_d = S_IRQ;
        end
      end
      S_IRQ: begin
        if (bus.start) result_d = ST_IRQ;
        if (bus.irq_ack) begin
          irq_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept && !rsp)      pending_d = pending_q + PEND_W'(1);
    else if (!accept && rsp) pending_d = pending_q - PEND_W'(1);
    if (rsp) wcnt_d = wcnt_q + CNT_W'(1);

    // read is computed from the post-update pending count so it never asserts at the limit
    if (state_d == S_ISSUE) begin
      read_d    = (pending_d < PEND_W'(MAX_PENDING));
      address_d = base_d + (ADDR_W'(row_d) * ADDR_W'(stride_d) + ADDR_W'(col_d)) * ADDR_W'(BYTES);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      dim_q     <= '0;
      stride_q  <= '0;
      nn_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wcnt_q    <= '0;
      pending_q <= '0;
      address_q <= '0;
      read_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      irq_q     <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      dim_q     <= dim_d;
      stride_q  <= stride_d;
      nn_q      <= nn_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wcnt_q    <= wcnt_d;
      pending_q <= pending_d;
      address_q <= address_d;
      read_q    <= read_d;
      done_q    <= done_d;
      result_q  <= result_d;
      irq_q     <= irq_d;
      ld_q      <= ld_d;
    end
  end

  matrix_buf_ram #(.DATA_W(DATA_W), .AW(BUF_AW)) u_buf (
    .clk     (clk),
    .we_i    (rsp),
    .waddr_i (wcnt_q[BUF_AW-1:0]),
    .wdata_i (bus.readdata),
    .raddr_i (bus.buf_rdaddr),
    .rdata_o (bus.buf_rddata)
  );

  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.address   = address_q;
  assign bus.read      = read_q;
  assign bus.irq       = irq_q;
  assign bus.load_done = ld_q;
endmodule
